flit_rx_monitor: RTL

- Receive-side monitor for the router characterization benches. It sits on the output port of a mux or router under test (`odata`/`ovalid`/`ovch`).
- It parses the HEAD/DATA/TAIL flit stream and checks packet framing. It accumulates packet, flit, error and bit-toggle statistics, which the energy characterization flow uses to correlate switching activity with power.
- It is purely observational: it drives nothing back into the network.

---
 rtl/flit_pkg.sv | 21 ++
 rtl/flit_rx_monitor_popcount.sv | 37 +++
 rtl/flit_rx_monitor.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/flit_pkg.sv
// Shared definitions for the flit receive-side monitor: flit type encoding,
// default field widths and the type-field decode helper.
package flit_pkg;

    localparam int FLIT_TYPE_W = 2;
    localparam int FLIT_DATA_W = 64;
    localparam int FLIT_VCH_W  = 2;

    typedef enum logic [FLIT_TYPE_W-1:0] {
        FLIT_NONE = 2'd0,
        FLIT_HEAD = 2'd1,
        FLIT_DATA = 2'd2,
        FLIT_TAIL = 2'd3
    } flit_type_e;

    // Interpret the raw type field (the MSBs of a flit) as a flit type.
    function automatic flit_type_e flit_type_of(input logic [FLIT_TYPE_W-1:0] field);
        return flit_type_e'(field);
    endfunction

endpackage

// File: rtl/flit_rx_monitor_popcount.sv
// Combinational population count built as a balanced binary adder tree.
// The input is padded to the next power of two; node[] is stored heap-style
// (root at 0, children of k at 2k+1 and 2k+2, leaves at N-1 .. 2N-2).
module popcount #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0]       data,
    output logic [$clog2(WIDTH):0] count
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int N      = 1 << LEVELS;
    localparam int OUT_W  = LEVELS + 1;

    logic [OUT_W-1:0] node [0:2*N-2];

    // Leaves: one input bit each, zero for the padding positions.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_leaf
            if (gi < WIDTH) begin : g_bit
                assign node[N-1+gi] = {{(OUT_W-1){1'b0}}, data[gi]};
            end else begin : g_pad
                assign node[N-1+gi] = '0;
            end
        end
    endgenerate

    // Internal nodes: sum of the two children; OUT_W bits cannot overflow.
    generate
        for (genvar gi = 0; gi < N-1; gi++) begin : g_node
            assign node[gi] = node[2*gi+1] + node[2*gi+2];
        end
    endgenerate

    assign count = node[0];

endmodule

// File: rtl/flit_rx_monitor.sv
// Receive-side flit stream monitor: checks HEAD/DATA/TAIL framing per packet
// and accumulates packet, flit, error and payload bit-toggle statistics.
// Purely observational; nothing is driven back into the network.
// Optional feature macro: FLIT_RX_TOGGLE_EN (toggle accumulator and popcount
// compiled in); when undefined, toggle_cnt is tied to zero.
module flit_rx_monitor
    import flit_pkg::*;
#(
    parameter int DATA_W  = FLIT_DATA_W,
    parameter int TYPE_W  = FLIT_TYPE_W,
    parameter int VCH_W   = FLIT_VCH_W,
    parameter int MAX_LEN = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [TYPE_W+DATA_W-1:0] idata,
    input  logic                     ivalid,
    input  logic [VCH_W-1:0]         ivch,
    input  logic                     clear,
    output logic [31:0]              pkt_cnt,
    output logic [31:0]              flit_cnt,
    output logic [15:0]              err_cnt,
    output logic [39:0]              toggle_cnt,
    output logic [15:0]              last_len,
    output logic                     busy,
    output logic                     err_pulse
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } state_e;

    state_e            state_reg, state_next;
    logic [VCH_W-1:0]  pkt_vch_reg, pkt_vch_next;
    logic [15:0]       len_reg, len_next;
    logic              err_det;
    logic              pkt_done;

    logic [31:0]       pkt_cnt_reg;
    logic [31:0]       flit_cnt_reg;
    logic [15:0]       err_cnt_reg;
    logic [15:0]       last_len_reg;
    logic              err_pulse_reg;

    flit_type_e        ftype;

    assign ftype = flit_type_of(FLIT_TYPE_W'(idata[TYPE_W+DATA_W-1:DATA_W]));

    // Packet state register; clear aborts any packet in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            pkt_vch_reg <= '0;
            len_reg     <= '0;
        end else if (clear) begin
            state_reg   <= ST_IDLE;
            pkt_vch_reg <= '0;
            len_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            pkt_vch_reg <= pkt_vch_next;
            len_reg     <= len_next;
        end
    end

    // Framing rules: next state, body length and error/completion detection.
    // Several error causes in one cycle collapse into a single err_det.
    always_comb begin
        state_next   = state_reg;
        pkt_vch_next = pkt_vch_reg;
        len_next     = len_reg;
        err_det      = 1'b0;
        pkt_done     = 1'b0;
        if (ivalid) begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (ftype == FLIT_HEAD) begin
                        state_next   = ST_BODY;
                        pkt_vch_next = ivch;
                        len_next     = '0;
                    end else begin
                        err_det = 1'b1;
                    end
                end
                ST_BODY: begin
                    // Checked against the VC latched by the current packet,
                    // before any relatch by a stray HEAD.
                    if (ivch != pkt_vch_reg) begin
                        err_det = 1'b1;
                    end
                    unique case (ftype)
                        FLIT_DATA: begin
                            if (len_reg >= 16'(MAX_LEN)) begin
                                err_det    = 1'b1;
                                state_next = ST_IDLE;
                            end else begin
                                len_next = len_reg + 16'd1;
                            end
                        end
                        FLIT_TAIL: begin
                            pkt_done   = 1'b1;
                            state_next = ST_IDLE;
                        end
                        FLIT_HEAD: begin
                            err_det      = 1'b1;
                            pkt_vch_next = ivch;
                            len_next     = '0;
                        end
                        default: begin
                            err_det    = 1'b1;
                            state_next = ST_IDLE;
                        end
                    endcase
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Saturating statistics counters and the per-error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt_reg   <= '0;
            flit_cnt_reg  <= '0;
            err_cnt_reg   <= '0;
            last_len_reg  <= '0;
            err_pulse_reg <= 1'b0;
        end else if (clear) begin
            pkt_cnt_reg   <= '0;
            flit_cnt_reg  <= '0;
            err_cnt_reg   <= '0;
            last_len_reg  <= '0;
            err_pulse_reg <= 1'b0;
        end else begin
            err_pulse_reg <= err_det;
            if (ivalid && (flit_cnt_reg != '1)) begin
                flit_cnt_reg <= flit_cnt_reg + 32'd1;
            end
            if (err_det && (err_cnt_reg != '1)) begin
                err_cnt_reg <= err_cnt_reg + 16'd1;
            end
            if (pkt_done) begin
                if (pkt_cnt_reg != '1) begin
                    pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
                end
                last_len_reg <= len_reg;
            end
        end
    end

`ifdef FLIT_RX_TOGGLE_EN
    localparam int POP_W = $clog2(DATA_W) + 1;

    logic [DATA_W-1:0] prev_payload_reg;
    logic [DATA_W-1:0] payload_xor;
    logic [POP_W-1:0]  pop_val;
    logic [40:0]       toggle_sum;
    logic [39:0]       toggle_cnt_reg;

    assign payload_xor = idata[DATA_W-1:0] ^ prev_payload_reg;
    // Extra MSB catches the carry so the accumulator can clamp at all-ones.
    assign toggle_sum  = {1'b0, toggle_cnt_reg} + 41'(pop_val);

    popcount #(
        .WIDTH (DATA_W)
    ) u_popcount (
        .data  (payload_xor),
        .count (pop_val)
    );

    // Toggle accumulator; clear also forgets the previous payload so the
    // next flit is compared against zero, as after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_payload_reg <= '0;
            toggle_cnt_reg   <= '0;
        end else if (clear) begin
            prev_payload_reg <= '0;
            toggle_cnt_reg   <= '0;
        end else if (ivalid) begin
            prev_payload_reg <= idata[DATA_W-1:0];
            toggle_cnt_reg   <= toggle_sum[40] ? '1 : toggle_sum[39:0];
        end
    end

    assign toggle_cnt = toggle_cnt_reg;
`else
    logic unused_payload;

    assign unused_payload = ^idata[DATA_W-1:0];
    assign toggle_cnt     = '0;
`endif

    assign pkt_cnt   = pkt_cnt_reg;
    assign flit_cnt  = flit_cnt_reg;
    assign err_cnt   = err_cnt_reg;
    assign last_len  = last_len_reg;
    assign busy      = (state_reg == ST_BODY);
    assign err_pulse = err_pulse_reg;

endmodule
